// File: rtl/store_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-cycle 32x8 store, round-robin on ties.
// Define STORE_ARB_LOADER_EN to add a fixed-priority loader port.
module store_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       f_req,
    input  logic [4:0] f_addr,
    output logic       f_ack,
    input  logic       d_req,
    input  logic       d_we,
    input  logic [4:0] d_addr,
    input  logic [7:0] d_wdata,
    output logic       d_ack,
`ifdef STORE_ARB_LOADER_EN
    input  logic       l_req,
    input  logic       l_we,
    input  logic [4:0] l_addr,
    input  logic [7:0] l_wdata,
    output logic       l_ack,
`endif
    output logic [7:0] rdata,
    output logic       ms_read,
    output logic       ms_write,
    output logic [4:0] ms_addr,
    output logic [7:0] ms_wdata,
    input  logic [7:0] ms_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [1:0] ID_F = 2'd0;
    localparam logic [1:0] ID_D = 2'd1;
`ifdef STORE_ARB_LOADER_EN
    localparam logic [1:0] ID_L = 2'd2;
`endif

    state_t      state_reg, state_next;
    logic [1:0]  id_reg, id_next;
    logic [4:0]  addr_reg, addr_next;
    logic        we_reg, we_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic        last_data_reg, last_data_next;
    logic [7:0]  rdata_reg, rdata_next;
    logic        pick_data;

    // Data wins when alone, or on a tie when fetch was granted last.
    assign pick_data = d_req && (!f_req || !last_data_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            id_reg        <= ID_F;
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            last_data_reg <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            id_reg        <= id_next;
            addr_reg      <= addr_next;
            we_reg        <= we_next;
            wdata_reg     <= wdata_next;
            last_data_reg <= last_data_next;
            rdata_reg     <= rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        id_next        = id_reg;
        addr_next      = addr_reg;
        we_next        = we_reg;
        wdata_next     = wdata_reg;
        last_data_next = last_data_reg;
        rdata_next     = rdata_reg;
        case (state_reg)
            IDLE: begin
`ifdef STORE_ARB_LOADER_EN
                // Loader pre-empts both ports and leaves the round-robin pointer alone.
                if (l_req) begin
                    state_next = ACCESS;
                    id_next    = ID_L;
                    addr_next  = l_addr;
                    we_next    = l_we;
                    wdata_next = l_wdata;
                end else
`endif
                if (f_req || d_req) begin
                    state_next = ACCESS;
                    if (pick_data) begin
                        id_next        = ID_D;
                        addr_next      = d_addr;
                        we_next        = d_we;
                        wdata_next     = d_wdata;
                        last_data_next = 1'b1;
                    end else begin
                        id_next        = ID_F;
                        addr_next      = f_addr;
                        we_next        = 1'b0;
                        wdata_next     = '0;
                        last_data_next = 1'b0;
                    end
                end
            end
            ACCESS: begin
                state_next = ACK;
                if (!we_reg) begin
                    rdata_next = ms_rdata;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Store strobes are decoded from the state register so an async reset kills them at once.
    assign ms_read  = (state_reg == ACCESS) && !we_reg;
    assign ms_write = (state_reg == ACCESS) && we_reg;
    assign ms_addr  = (state_reg == ACCESS) ? addr_reg  : 5'd0;
    assign ms_wdata = (state_reg == ACCESS) ? wdata_reg : 8'd0;

    assign f_ack = (state_reg == ACK) && (id_reg == ID_F);
    assign d_ack = (state_reg == ACK) && (id_reg == ID_D);
`ifdef STORE_ARB_LOADER_EN
    assign l_ack = (state_reg == ACK) && (id_reg == ID_L);
`endif
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_store_arbiter.sv
// Scoreboard bench for store_arbiter: expected acks are queued at drive time, popped by an ack monitor.
// Define STORE_ARB_LOADER_EN to exercise the loader port as well.
module tb_store_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       f_req = 1'b0;
    logic [4:0] f_addr = '0;
    logic       f_ack;
    logic       d_req = 1'b0;
    logic       d_we = 1'b0;
    logic [4:0] d_addr = '0;
    logic [7:0] d_wdata = '0;
    logic       d_ack;
    logic [7:0] rdata;
    logic       ms_read;
    logic       ms_write;
    logic [4:0] ms_addr;
    logic [7:0] ms_wdata;
    logic [7:0] ms_rdata;
    logic       l_ack_w;
`ifdef STORE_ARB_LOADER_EN
    logic       l_req = 1'b0;
    logic       l_we = 1'b0;
    logic [4:0] l_addr = '0;
    logic [7:0] l_wdata = '0;
    logic       l_ack;
    assign l_ack_w = l_ack;
`else
    assign l_ack_w = 1'b0;
`endif

    store_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
`ifdef STORE_ARB_LOADER_EN
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
`endif
        .rdata(rdata),
        .ms_read(ms_read), .ms_write(ms_write), .ms_addr(ms_addr), .ms_wdata(ms_wdata),
        .ms_rdata(ms_rdata)
    );

    always #5 clk = ~clk;

    // Store model and the bench's own shadow of what it should contain.
    logic [7:0] mem    [32];
    logic [7:0] shadow [32];
    assign ms_rdata = mem[ms_addr];
    always @(posedge clk) if (ms_write) mem[ms_addr] <= ms_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    typedef struct { int port; logic rd; logic [7:0] data; } exp_t;
    exp_t exp_q[$];
    int   ack_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void push_exp(input int port, input logic we, input logic [4:0] a,
                                     input logic [7:0] wd);
        exp_t e;
        e.port = port;
        e.rd   = !we;
        e.data = shadow[a];
        exp_q.push_back(e);
        if (we) shadow[a] = wd;
    endfunction

    function automatic logic ack_of(input int port);
        case (port)
            0:       return f_ack;
            1:       return d_ack;
            default: return l_ack_w;
        endcase
    endfunction

    // Ack monitor: one line per completed transaction, checked against the scoreboard.
    logic [1:0] nack;
    int         mport;
    exp_t       me;
    always @(negedge clk) begin
        nack = {1'b0, f_ack} + {1'b0, d_ack} + {1'b0, l_ack_w};
        if (nack != 2'd0) begin
            mport = d_ack ? 1 : (f_ack ? 0 : 2);
            $display("ack port=%0d rdata=%02h cycle=%0d", mport, rdata, cyc);
            check("ack_onehot", 32'(nack), 32'd1);
            ack_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'(mport), 32'd99);
            end else begin
                me = exp_q.pop_front();
                check("ack_port", 32'(mport), 32'(me.port));
                if (me.rd) check("ack_rdata", 32'(rdata), 32'(me.data));
            end
        end
    end

    task automatic run_req(input int port, input logic we, input logic [4:0] a,
                           input logic [7:0] wd, input int exp_lat);
        int   n;
        logic ack;
        @(negedge clk);
        case (port)
            0: begin f_addr = a; f_req = 1'b1; end
            1: begin d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1; end
            default: begin
`ifdef STORE_ARB_LOADER_EN
                l_we = we; l_addr = a; l_wdata = wd; l_req = 1'b1;
`endif
            end
        endcase
        n = 0;
        do begin
            @(negedge clk);
            n++;
            ack = ack_of(port);
            if (n == exp_lat - 1) begin
                check("ms_write", 32'(ms_write), 32'(we));
                check("ms_read", 32'(ms_read), 32'(!we));
                check("ms_addr", 32'(ms_addr), 32'(a));
                check("ms_wdata", 32'(ms_wdata), we ? 32'(wd) : 32'd0);
            end
            if (n == exp_lat) begin
                check("ms_quiet_in_ack", {30'd0, ms_write, ms_read}, 32'd0);
            end
        end while (!ack && n < 20);
        check("ack_latency", 32'(n), 32'(exp_lat));
        @(posedge clk);
        #1;
        case (port)
            0: f_req = 1'b0;
            1: d_req = 1'b0;
            default: begin
`ifdef STORE_ARB_LOADER_EN
                l_req = 1'b0;
`endif
            end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_acks", {30'd0, f_ack, d_ack}, 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_ms_strobes", {30'd0, ms_read, ms_write}, 32'd0);
        check("rst_ms_addr", 32'(ms_addr), 32'd0);
        check("rst_ms_wdata", 32'(ms_wdata), 32'd0);
        rst = 1'b1;
        ack_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        for (int i = 0; i < 32; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        do_reset();

        // Write A5 to 3 via data, read it back via fetch.
        push_exp(1, 1'b1, 5'd3, 8'hA5);
        run_req(1, 1'b1, 5'd3, 8'hA5, 2);
        push_exp(0, 1'b0, 5'd3, 8'h00);
        run_req(0, 1'b0, 5'd3, 8'h00, 2);
        check("rdata_after_fetch", 32'(rdata), 32'hA5);

        // A write following a read must not disturb rdata.
        push_exp(1, 1'b1, 5'd9, 8'h11);
        run_req(1, 1'b1, 5'd9, 8'h11, 2);
        push_exp(0, 1'b0, 5'd9, 8'h00);
        run_req(0, 1'b0, 5'd9, 8'h00, 2);
        push_exp(1, 1'b1, 5'd10, 8'h3C);
        run_req(1, 1'b1, 5'd10, 8'h3C, 2);
        check("rdata_hold_over_write", 32'(rdata), 32'h11);

        // Simultaneous requests straight after reset: data first, then fetch.
        do_reset();
        push_exp(1, 1'b0, 5'd3, 8'h00);
        push_exp(0, 1'b0, 5'd9, 8'h00);
        fork
            run_req(1, 1'b0, 5'd3, 8'h00, 2);
            run_req(0, 1'b0, 5'd9, 8'h00, 5);
        join
        check("tie_ack_count", 32'(ack_cyc.size()), 32'd2);
        if (ack_cyc.size() == 2) check("tie_ack_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);

        // Both held for six accesses: strict d,f alternation.
        do_reset();
        @(negedge clk);
        f_addr = 5'd9; d_addr = 5'd10; d_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(1, 1'b0, 5'd10, 8'h00);
            push_exp(0, 1'b0, 5'd9, 8'h00);
        end
        f_req = 1'b1; d_req = 1'b1;
        k = 0; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (f_ack || d_ack) k++;
        end while (k < 6 && n < 60);
        check("alt_ack_count", 32'(k), 32'd6);
        @(posedge clk);
        #1;
        f_req = 1'b0; d_req = 1'b0;
        for (int i = 1; i < ack_cyc.size(); i++)
            check("alt_ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);

        // Reset during the ACCESS cycle of a write to 7: aborted, never retried.
        @(negedge clk);
        d_we = 1'b1; d_addr = 5'd7; d_wdata = 8'h5A; d_req = 1'b1;
        @(negedge clk);
        check("abort_ms_write_before", 32'(ms_write), 32'd1);
        check("abort_ms_addr_before", 32'(ms_addr), 32'd7);
        rst = 1'b0;
        #1;
        check("abort_ms_write_drop", 32'(ms_write), 32'd0);
        check("abort_ms_addr_drop", 32'(ms_addr), 32'd0);
        @(negedge clk);
        d_req = 1'b0;
        check("abort_no_ack", 32'(d_ack), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_retry", {30'd0, ms_write, d_ack}, 32'd0);
        end
        push_exp(0, 1'b0, 5'd7, 8'h00);
        run_req(0, 1'b0, 5'd7, 8'h00, 2);

`ifdef STORE_ARB_LOADER_EN
        // Loader beats both ports; data then fetch after it.
        do_reset();
        push_exp(2, 1'b0, 5'd3, 8'h00);
        push_exp(1, 1'b0, 5'd9, 8'h00);
        push_exp(0, 1'b0, 5'd10, 8'h00);
        fork
            run_req(2, 1'b0, 5'd3, 8'h00, 2);
            run_req(1, 1'b0, 5'd9, 8'h00, 5);
            run_req(0, 1'b0, 5'd10, 8'h00, 8);
        join
        check("loader_ack_count", 32'(ack_cyc.size()), 32'd3);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_arbiter.md
STORE_ARBITER -- requirements
Module: store_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port f_req, input, 1 bit: fetch read request, held until f_ack.
REQ-004 The block SHALL have port f_addr, input, 5 bits: fetch address.
REQ-005 The block SHALL have port f_ack, output, 1 bit: one-cycle fetch completion pulse.
REQ-006 The block SHALL have port d_req, input, 1 bit: data-port request, held until d_ack.
REQ-007 The block SHALL have port d_we, input, 1 bit: data-port write (1) or read (0).
REQ-008 The block SHALL have port d_addr, input, 5 bits: data-port address.
REQ-009 The block SHALL have port d_wdata, input, 8 bits: data-port write data.
REQ-010 The block SHALL have port d_ack, output, 1 bit: one-cycle data-port completion pulse.
REQ-011 The block SHALL have port rdata, output, 8 bits: read result shared by all ports, valid with ack.
REQ-012 The block SHALL have port ms_read, output, 1 bit: store read strobe.
REQ-013 The block SHALL have port ms_write, output, 1 bit: store write strobe.
REQ-014 The block SHALL have port ms_addr, output, 5 bits: store address.
REQ-015 The block SHALL have port ms_wdata, output, 8 bits: store write data.
REQ-016 The block SHALL have port ms_rdata, input, 8 bits: store read data, combinational from ms_addr.

Function
REQ-017 The block SHALL implement FSM states IDLE, ACCESS and ACK, with transitions IDLE->ACCESS on any sampled request, ACCESS->ACK unconditionally, and ACK->IDLE unconditionally.
REQ-018 In IDLE, the block SHALL select a winner, latch its id, address, we and wdata (fetch: we=0), and enter ACCESS on the next edge.
REQ-019 With exactly one request pending, the block SHALL grant that requester.
REQ-020 With both requests pending, the block SHALL grant round-robin, awarding the requester not granted last.
REQ-021 In ACCESS (exactly one cycle), the block SHALL drive ms_addr and ms_wdata from the latched values, with ms_write=we and ms_read=!we.
REQ-022 For reads, the block SHALL register ms_rdata into rdata at the ACCESS->ACK edge.
REQ-023 In ACK, the block SHALL pulse the winner's ack high for one cycle, with rdata valid in that cycle for reads.
REQ-024 The block SHALL drive ms_read, ms_write, ms_addr and ms_wdata to 0 outside ACCESS.
REQ-025 The block SHALL complete an access even if the requester drops req mid-access, with the ack still pulsed.
REQ-026 The block SHALL treat req still high in the cycle after ack as a new request.
REQ-027 The block SHALL hold rdata until the next read capture; writes SHALL NOT change rdata.
REQ-028 Latency SHALL be: request sampled in IDLE at edge N, ACCESS in cycle N+1, ack in cycle N+2; minimum spacing 3 cycles per access.
REQ-029 Fairness SHALL be: a pending requester waits at most one other access before being granted.

Reset
REQ-030 While rst=0, the block SHALL force the FSM to IDLE, f_ack=d_ack=0, rdata=0, all ms_* outputs=0, and the last-grant pointer=fetch (so data wins the first tie).
REQ-031 Reset asserted during ACCESS SHALL drop ms_write immediately, produce no ack, and not retry the access after release.

Configuration
REQ-032 When macro STORE_ARB_LOADER_EN is defined, the block SHALL add ports l_req (in, 1), l_we (in, 1), l_addr (in, 5), l_wdata (in, 8) and l_ack (out, 1), following the data-port protocol.
REQ-033 With STORE_ARB_LOADER_EN defined, a loader request SHALL have fixed priority over fetch and data, and SHALL not update the round-robin pointer.
REQ-034 Without STORE_ARB_LOADER_EN, the loader ports SHALL be absent and behaviour SHALL be two-port only.

Verification
REQ-035 The bench SHALL cover: d_req, d_we=1, d_addr=5'd3, d_wdata=8'hA5 -> ms_write=1 with ms_addr=3 for one cycle, d_ack 2 cycles after sample; then f_req at f_addr=3 -> rdata=8'hA5 with f_ack.
REQ-036 The bench SHALL cover: f_req and d_req together straight after reset -> data granted first, then fetch; acks spaced 3 cycles.
REQ-037 The bench SHALL cover: both requests held for 6 accesses -> grants strictly alternate d,f,d,f,d,f.
REQ-038 The bench SHALL cover: rst=0 during the ACCESS cycle of a write to 5'd7 -> no ack, ms_write=0 immediately, FSM in IDLE after release.
REQ-039 The bench SHALL cover: a write of 8'h3C following a read that returned 8'h11 -> rdata stays 8'h11.
REQ-040 With STORE_ARB_LOADER_EN defined, the bench SHALL cover: l_req, f_req and d_req together -> loader granted first, then data, then fetch.
